fir_systolic_tap: RTL and testbench



---
 rtl/fir_pkg.sv | 17 +
 rtl/fir_systolic_tap_if.sv | 13 +
 rtl/fir_systolic_tap_delay.sv | 9 +
 rtl/fir_systolic_tap.sv | 37 +++
 tb/tb_fir_systolic_tap.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, rounding constant and saturation helper for the FIR taps
package fir_pkg;
  localparam int FIR_DATA_WIDTH = 16;
  localparam int FIR_DATA_WIDTH_F = 14;
  localparam int FIR_ROUND_C = 1 << (FIR_DATA_WIDTH_F - 1);
  function automatic int round_const(input int f);
    return 1 << (f - 1);
  endfunction
  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    return x > mx ? mx : x < mn ? mn : x;
  endfunction
endpackage

// File: rtl/fir_systolic_tap_if.sv
// fir_systolic_tap_if: sample, partial-sum and coefficient signals of one tap
interface fir_systolic_tap_if import fir_pkg::*; #(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH
);
  logic enable;
  logic signed [DATA_WIDTH-1:0] a_in;
  logic signed [DATA_WIDTH-1:0] b_in;
  logic signed [DATA_WIDTH-1:0] h_in;
  logic signed [DATA_WIDTH-1:0] a_out;
  logic signed [DATA_WIDTH-1:0] b_out;
  modport master (output enable, a_in, b_in, h_in, input a_out, b_out);
  modport slave (input enable, a_in, b_in, h_in, output a_out, b_out);
endinterface

// File: rtl/fir_systolic_tap_delay.sv
// delay: zero-latency pass-through marking a systolic stage boundary
module delay #(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [DATA_WIDTH-1:0] data_out
);
  assign data_out = data_in;
endmodule

// File: rtl/fir_systolic_tap.sv
// fir_systolic_tap: one systolic FIR tap, b_out = sat(b_in + round(a_in[n-1] * h_in))
module fir_systolic_tap import fir_pkg::*; #(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int DATA_WIDTH_F = FIR_DATA_WIDTH_F
) (
  input logic clk,
  input logic reset,
  fir_systolic_tap_if.slave bus
);
  logic signed [DATA_WIDTH-1:0] a_r1_q, a_r1_d, a_r2_q, a_r2_d, b_r_q, b_r_d;
  logic signed [2*DATA_WIDTH-1:0] p, pr;
  logic signed [DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH:0] sum;
  // The product uses a_r1, so the sum path runs one stage behind the sample path.
  always_comb begin
    p = (2*DATA_WIDTH)'(a_r1_q) * (2*DATA_WIDTH)'(bus.h_in);
    pr = (p + (2*DATA_WIDTH)'(round_const(DATA_WIDTH_F))) >>> DATA_WIDTH_F;
    prod = DATA_WIDTH'(sat(64'(pr), DATA_WIDTH));
    sum = (DATA_WIDTH+1)'(bus.b_in) + (DATA_WIDTH+1)'(prod);
    a_r1_d = bus.enable ? bus.a_in : a_r1_q;
    a_r2_d = bus.enable ? a_r1_q : a_r2_q;
    b_r_d = bus.enable ? DATA_WIDTH'(sat(64'(sum), DATA_WIDTH)) : b_r_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r1_q <= '0;
      a_r2_q <= '0;
      b_r_q <= '0;
    end else begin
      a_r1_q <= a_r1_d;
      a_r2_q <= a_r2_d;
      b_r_q <= b_r_d;
    end
  end
  delay #(.DATA_WIDTH(DATA_WIDTH)) u_delay_a (.data_in(a_r2_q), .data_out(bus.a_out));
  delay #(.DATA_WIDTH(DATA_WIDTH)) u_delay_b (.data_in(b_r_q), .data_out(bus.b_out));
endmodule

// File: tb/tb_fir_systolic_tap.sv
// tb_fir_systolic_tap: directed + random checks of one tap against a timing-rule model, plus a 3-tap chain
module tb_fir_systolic_tap;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;

  fir_systolic_tap_if bus ();
  fir_systolic_tap u_dut (.clk(clk), .reset(reset), .bus(bus));

  fir_systolic_tap_if c0 ();
  fir_systolic_tap_if c1 ();
  fir_systolic_tap_if c2 ();
  fir_systolic_tap u_t0 (.clk(clk), .reset(reset), .bus(c0));
  fir_systolic_tap u_t1 (.clk(clk), .reset(reset), .bus(c1));
  fir_systolic_tap u_t2 (.clk(clk), .reset(reset), .bus(c2));
  delay #(.DATA_WIDTH(16)) d_a1 (.data_in(c0.a_out), .data_out(c1.a_in));
  delay #(.DATA_WIDTH(16)) d_b1 (.data_in(c0.b_out), .data_out(c1.b_in));
  delay #(.DATA_WIDTH(16)) d_a2 (.data_in(c1.a_out), .data_out(c2.a_in));
  delay #(.DATA_WIDTH(16)) d_b2 (.data_in(c1.b_out), .data_out(c2.b_in));
  assign c0.enable = 1'b1;
  assign c1.enable = 1'b1;
  assign c2.enable = 1'b1;
  assign c0.b_in = '0;
  assign c0.h_in = 16'sh4000;
  assign c1.h_in = 16'sh2000;
  assign c2.h_in = 16'sh1000;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sat16(input longint x);
    return x > 32767 ? 32767 : x < -32768 ? -32768 : x;
  endfunction

  // Reference: outputs after enabled edge n follow from the enabled-cycle input history.
  int hist[$];
  int exp_a = 0;
  int exp_b = 0;
  bit mvalid = 1'b0;
  always @(posedge clk) begin
    if (reset) begin
      hist.delete();
      exp_a = 0;
      exp_b = 0;
      mvalid = 1'b1;
    end else if (bus.enable) begin
      longint prev;
      longint prod;
      prev = hist.size() > 0 ? longint'(hist[$]) : 0;
      prod = sat16((prev * longint'(bus.h_in) + 8192) >>> 14);
      exp_a = int'(prev);
      exp_b = int'(sat16(longint'(bus.b_in) + prod));
      hist.push_back(int'(bus.a_in));
      if (hist.size() > 4) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_a_out", int'(bus.a_out), exp_a);
      chk("model_b_out", int'(bus.b_out), exp_b);
    end
  end

  task automatic cyc(input logic rs, input logic en, input int a, input int b, input int h);
    reset = rs;
    bus.enable = en;
    bus.a_in = 16'(a);
    bus.b_in = 16'(b);
    bus.h_in = 16'(h);
    @(negedge clk);
  endtask

  int cv[8];
  int corner[6] = '{32767, -32768, 0, 1, -1, 16384};

  initial begin
    c0.a_in = '0;
    bus.enable = 1'b1;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.h_in = '0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 1234, 77, 16'h4000);
      chk("reset_a", int'(bus.a_out), 0);
      chk("reset_b", int'(bus.b_out), 0);
    end
    cyc(1'b0, 1'b1, 100, 0, 16'h4000);
    chk("unity_first_b", int'(bus.b_out), 0);
    cyc(1'b0, 1'b1, 0, 0, 16'h4000);
    chk("unity_b", int'(bus.b_out), 100);
    chk("unity_a", int'(bus.a_out), 100);
    cyc(1'b0, 1'b1, 0, 0, 16'h4000);
    chk("unity_b_clear", int'(bus.b_out), 0);
    chk("unity_a_clear", int'(bus.a_out), 0);
    cyc(1'b0, 1'b1, 3, 0, 16'h2000);
    cyc(1'b0, 1'b1, -3, 0, 16'h2000);
    chk("round_p3", int'(bus.b_out), 2);
    cyc(1'b0, 1'b1, 1, 0, 16'h2000);
    chk("round_m3", int'(bus.b_out), -1);
    cyc(1'b0, 1'b1, 0, 0, 16'h2000);
    chk("round_p1", int'(bus.b_out), 1);
    cyc(1'b0, 1'b1, 32767, 32767, 16'h4000);
    cyc(1'b0, 1'b1, -32768, 32767, 16'h4000);
    chk("sat_pos", int'(bus.b_out), 32767);
    cyc(1'b0, 1'b1, -32768, -32768, 16'h4000);
    chk("sat_neg", int'(bus.b_out), -32768);
    cyc(1'b0, 1'b1, 0, 0, 16'h8000);
    chk("sat_prod", int'(bus.b_out), 32767);
    cyc(1'b0, 1'b1, 0, 0, 16'h4000);
    cyc(1'b0, 1'b1, 0, 0, 16'h4000);
    cyc(1'b0, 1'b1, 50, 0, 16'h4000);
    chk("stall_load_b", int'(bus.b_out), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768, 16'h4000);
      chk("stall_frozen_b", int'(bus.b_out), 0);
      chk("stall_frozen_a", int'(bus.a_out), 0);
    end
    cyc(1'b0, 1'b1, 0, 0, 16'h4000);
    chk("stall_resume_b", int'(bus.b_out), 50);
    chk("stall_resume_a", int'(bus.a_out), 50);
    for (int i = 0; i < 500; i++) begin
      int a;
      int h;
      a = $urandom_range(0, 7) == 0 ? corner[$urandom_range(0, 5)] : $urandom_range(0, 65535) - 32768;
      h = $urandom_range(0, 7) == 0 ? corner[$urandom_range(0, 5)] : $urandom_range(0, 65535) - 32768;
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, a, $urandom_range(0, 65535) - 32768, h);
    end
    cyc(1'b1, 1'b1, 0, 0, 0);
    reset = 1'b0;
    c0.a_in = 16'sd1000;
    @(negedge clk);
    cv[0] = int'(c2.b_out);
    c0.a_in = '0;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      cv[i] = int'(c2.b_out);
    end
    chk("chain_quiet", cv[2], 0);
    chk("chain_h0", cv[3], 1000);
    chk("chain_h1", cv[4], 500);
    chk("chain_h2", cv[5], 250);
    chk("chain_done", cv[6], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
